// File: rtl/chip_7458_bist_pkg.sv
// Shared definitions for the chip_7458 self-test stage: widths, vector bit
// positions, FSM state encodings and the AND-OR reference equations.
package chip_7458_bist_pkg;

    localparam int VEC_W = 10;
    localparam int ERR_W = 11;

    // Position of each chip input inside the sweep vector.
    localparam int IDX_P1A = 0;
    localparam int IDX_P1B = 1;
    localparam int IDX_P1C = 2;
    localparam int IDX_P1D = 3;
    localparam int IDX_P1E = 4;
    localparam int IDX_P1F = 5;
    localparam int IDX_P2A = 6;
    localparam int IDX_P2B = 7;
    localparam int IDX_P2C = 8;
    localparam int IDX_P2D = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Section 1: two 3-input ANDs feeding an OR.
    function automatic logic golden_p1y(input logic [VEC_W-1:0] v);
        return (v[IDX_P1A] & v[IDX_P1B] & v[IDX_P1C]) |
               (v[IDX_P1D] & v[IDX_P1E] & v[IDX_P1F]);
    endfunction

    // Section 2: two 2-input ANDs feeding an OR.
    function automatic logic golden_p2y(input logic [VEC_W-1:0] v);
        return (v[IDX_P2A] & v[IDX_P2B]) | (v[IDX_P2C] & v[IDX_P2D]);
    endfunction

endpackage

// File: rtl/chip_7458_bist_if.sv
// Bundle of the self-test stage's run control, chip pins and result status.
// master = the BIST engine, slave = the board / bench side.
interface chip_7458_bist_if;
    import chip_7458_bist_pkg::*;

    logic             start;
    logic             p1a, p1b, p1c, p1d, p1e, p1f;
    logic             p2a, p2b, p2c, p2d;
    logic             p1y, p2y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [VEC_W-1:0] first_err_vec;
    logic             first_err_valid;

    modport master (
        input  start, p1y, p2y,
        output p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d,
        output busy, done, pass, err_count, first_err_vec, first_err_valid
    );

    modport slave (
        output start, p1y, p2y,
        input  p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d,
        input  busy, done, pass, err_count, first_err_vec, first_err_valid
    );

endinterface

// File: rtl/chip_7458_ref.sv
// Combinational golden model of the chip_7458 AND-OR block, indexed by the
// sweep vector so any bench or checker can reuse it.
module chip_7458_ref
    import chip_7458_bist_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_p1y,
    output logic             exp_p2y
);

    assign exp_p1y = golden_p1y(vec);
    assign exp_p2y = golden_p2y(vec);

endmodule

// File: rtl/chip_7458_bist.sv
// Exhaustive self-test of a chip_7458: sweeps vectors 0..LAST_VEC onto the
// chip inputs, holds each for SETTLE_CYCLES, then compares p1y/p2y with the
// reference model for one cycle. Reports error count and first failing vector.
module chip_7458_bist
    import chip_7458_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LAST_VEC      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    chip_7458_bist_if.master  bus
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_V      = VEC_W'(LAST_VEC);

    state_t           state_r, state_n;
    logic [VEC_W-1:0] vec_r, vec_n;
    logic [SW-1:0]    settle_r, settle_n;
    logic [ERR_W-1:0] err_r, err_n;
    logic [VEC_W-1:0] fev_r, fev_n;
    logic             fevalid_r, fevalid_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;
    logic             pass_r, pass_n;
    logic [VEC_W-1:0] drive_r, drive_n;

    logic             exp_p1y_s;
    logic             exp_p2y_s;
    logic             mismatch_s;

    chip_7458_ref u_ref (
        .vec     (vec_r),
        .exp_p1y (exp_p1y_s),
        .exp_p2y (exp_p2y_s)
    );

    // Case-inequality so an X/Z chip output is treated as a failure in simulation.
    assign mismatch_s = (bus.p1y !== exp_p1y_s) || (bus.p2y !== exp_p2y_s);

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_n   = state_r;
        vec_n     = vec_r;
        settle_n  = settle_r;
        err_n     = err_r;
        fev_n     = fev_r;
        fevalid_n = fevalid_r;
        busy_n    = busy_r;
        done_n    = done_r;
        drive_n   = drive_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_n   = ST_APPLY;
                    vec_n     = {VEC_W{1'b0}};
                    settle_n  = {SW{1'b0}};
                    err_n     = {ERR_W{1'b0}};
                    fev_n     = {VEC_W{1'b0}};
                    fevalid_n = 1'b0;
                    busy_n    = 1'b1;
                    done_n    = 1'b0;
                    drive_n   = {VEC_W{1'b0}};
                end else begin
                    state_n = state_r;
                end
            end
            ST_APPLY: begin
                if (settle_r == SETTLE_LAST) begin
                    state_n  = ST_CHECK;
                    settle_n = {SW{1'b0}};
                end else begin
                    settle_n = settle_r + SW'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_n = err_r + ERR_W'(1);
                    if (!fevalid_r) begin
                        fev_n     = vec_r;
                        fevalid_n = 1'b1;
                    end else begin
                        fev_n = fev_r;
                    end
                end else begin
                    err_n = err_r;
                end
                // The sweep ends on LAST_VEC; vec is never advanced past it.
                if (vec_r == LAST_V) begin
                    state_n = ST_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    drive_n = {VEC_W{1'b0}};
                end else begin
                    state_n = ST_APPLY;
                    vec_n   = vec_r + VEC_W'(1);
                    drive_n = vec_r + VEC_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b0;
                drive_n = {VEC_W{1'b0}};
            end
        endcase
        pass_n = done_n && (err_n == {ERR_W{1'b0}});
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            vec_r     <= {VEC_W{1'b0}};
            settle_r  <= {SW{1'b0}};
            err_r     <= {ERR_W{1'b0}};
            fev_r     <= {VEC_W{1'b0}};
            fevalid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            drive_r   <= {VEC_W{1'b0}};
        end else begin
            state_r   <= state_n;
            vec_r     <= vec_n;
            settle_r  <= settle_n;
            err_r     <= err_n;
            fev_r     <= fev_n;
            fevalid_r <= fevalid_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            pass_r    <= pass_n;
            drive_r   <= drive_n;
        end
    end

    assign bus.p1a = drive_r[IDX_P1A];
    assign bus.p1b = drive_r[IDX_P1B];
    assign bus.p1c = drive_r[IDX_P1C];
    assign bus.p1d = drive_r[IDX_P1D];
    assign bus.p1e = drive_r[IDX_P1E];
    assign bus.p1f = drive_r[IDX_P1F];
    assign bus.p2a = drive_r[IDX_P2A];
    assign bus.p2b = drive_r[IDX_P2B];
    assign bus.p2c = drive_r[IDX_P2C];
    assign bus.p2d = drive_r[IDX_P2D];

    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.pass            = pass_r;
    assign bus.err_count       = err_r;
    assign bus.first_err_vec   = fev_r;
    assign bus.first_err_valid = fevalid_r;

endmodule

// File: tb/tb_chip_7458_bist.sv
// Directed bench for chip_7458_bist: a full-size instance and a short-sweep
// instance, each wired to a behavioural chip_7458 with selectable faults.
module tb_chip_7458_bist;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Chip fault modes: 0 good, 1 p2y stuck-0, 2 p1y stuck-1.
    int   mode0;
    int   mode1;
    logic glitch_en;

    chip_7458_bist_if bus0 ();
    chip_7458_bist_if bus1 ();

    chip_7458_bist u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    chip_7458_bist #(.SETTLE_CYCLES(1), .LAST_VEC(15)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [9:0] pins0;
    logic [9:0] pins1;
    logic [9:0] prev1;
    logic       good1_0, good2_0, good1_1, good2_1, glitch1;

    assign pins0 = {bus0.p2d, bus0.p2c, bus0.p2b, bus0.p2a,
                    bus0.p1f, bus0.p1e, bus0.p1d, bus0.p1c, bus0.p1b, bus0.p1a};
    assign pins1 = {bus1.p2d, bus1.p2c, bus1.p2b, bus1.p2a,
                    bus1.p1f, bus1.p1e, bus1.p1d, bus1.p1c, bus1.p1b, bus1.p1a};

    assign good1_0 = (bus0.p1a & bus0.p1b & bus0.p1c) | (bus0.p1d & bus0.p1e & bus0.p1f);
    assign good2_0 = (bus0.p2a & bus0.p2b) | (bus0.p2c & bus0.p2d);
    assign good1_1 = (bus1.p1a & bus1.p1b & bus1.p1c) | (bus1.p1d & bus1.p1e & bus1.p1f);
    assign good2_1 = (bus1.p2a & bus1.p2b) | (bus1.p2c & bus1.p2d);

    // Glitch p1y for the first half-cycle after the short instance's pins move.
    always @(negedge clk) prev1 <= pins1;
    assign glitch1 = glitch_en && (pins1 != prev1);

    assign bus0.p1y = (mode0 == 2) ? 1'b1 : good1_0;
    assign bus0.p2y = (mode0 == 1) ? 1'b0 : good2_0;
    assign bus1.p1y = (mode1 == 2) ? 1'b1 : (good1_1 ^ glitch1);
    assign bus1.p2y = (mode1 == 1) ? 1'b0 : good2_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start(input int which);
        @(posedge clk);
        #1;
        if (which == 0) bus0.start = 1'b1;
        else            bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic run_big(output int cycles);
        int n;
        pulse_start(0);
        n = 0;
        while (bus0.busy && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        cycles = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus0.busy); end
        total++; if (bus0.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus0.done); end
        total++; if (bus0.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", bus0.pass); end
        total++; if (bus0.err_count !== 11'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", bus0.err_count); end
        total++; if (bus0.first_err_valid !== 1'b0) begin bad++; $display("FAIL reset_fevalid got=%b want=0", bus0.first_err_valid); end
        total++; if (pins0 !== 10'd0) begin bad++; $display("FAIL reset_pins got=%h want=000", pins0); end
        total++; if (pins1 !== 10'd0 || bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_small got pins=%h busy=%b want 000/0", pins1, bus1.busy); end
        rst = 1'b0;
    endtask

    // Short sweep with APPLY-phase glitches, vector-5 pin timing, ignored start.
    task automatic test_small_run();
        int n;
        mode1 = 0;
        glitch_en = 1'b1;
        pulse_start(1);
        n = 0;
        while (bus1.busy && n < 100) begin
            if (n == 9) begin
                total++; if (pins1 !== 10'h004) begin bad++; $display("FAIL vec4_check_pins got=%h want=004", pins1); end
            end
            if (n == 10) begin
                total++; if (pins1 !== 10'h005) begin bad++; $display("FAIL vec5_apply_pins got=%h want=005", pins1); end
            end
            if (n == 14) bus1.start = 1'b1;
            if (n == 15) bus1.start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        glitch_en = 1'b0;
        total++; if (n !== 32) begin bad++; $display("FAIL small_busy_cycles got=%0d want=32", n); end
        total++; if (bus1.done !== 1'b1) begin bad++; $display("FAIL small_done got=%b want=1", bus1.done); end
        total++; if (bus1.err_count !== 11'd0) begin bad++; $display("FAIL small_glitch_err got=%0d want=0", bus1.err_count); end
        total++; if (bus1.pass !== 1'b1) begin bad++; $display("FAIL small_pass got=%b want=1", bus1.pass); end
        total++; if (pins1 !== 10'd0) begin bad++; $display("FAIL small_done_pins got=%h want=000", pins1); end
    endtask

    // Faulty run then restart from DONE; counters must clear on the start edge.
    task automatic test_small_restart();
        int n;
        mode1 = 2;
        pulse_start(1);
        n = 0;
        while (bus1.busy && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (bus1.err_count !== 11'd14) begin bad++; $display("FAIL small_p1y1_err got=%0d want=14", bus1.err_count); end
        total++; if (bus1.first_err_vec !== 10'd0 || bus1.first_err_valid !== 1'b1) begin bad++; $display("FAIL small_p1y1_first got=%0d/%b want=0/1", bus1.first_err_vec, bus1.first_err_valid); end
        total++; if (bus1.pass !== 1'b0) begin bad++; $display("FAIL small_p1y1_pass got=%b want=0", bus1.pass); end
        mode1 = 0;
        pulse_start(1);
        total++; if (bus1.err_count !== 11'd0 || bus1.first_err_valid !== 1'b0) begin bad++; $display("FAIL restart_clear got=%0d/%b want=0/0", bus1.err_count, bus1.first_err_valid); end
        total++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b1) begin bad++; $display("FAIL restart_flags got done=%b busy=%b want 0/1", bus1.done, bus1.busy); end
        n = 0;
        while (bus1.busy && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n !== 32 || bus1.pass !== 1'b1) begin bad++; $display("FAIL restart_run got cycles=%0d pass=%b want 32/1", n, bus1.pass); end
    endtask

    task automatic test_clean_run();
        int c;
        mode0 = 0;
        run_big(c);
        total++; if (c !== 3072) begin bad++; $display("FAIL clean_busy_cycles got=%0d want=3072", c); end
        total++; if (bus0.done !== 1'b1 || bus0.pass !== 1'b1) begin bad++; $display("FAIL clean_done_pass got=%b/%b want=1/1", bus0.done, bus0.pass); end
        total++; if (bus0.err_count !== 11'd0 || bus0.first_err_valid !== 1'b0) begin bad++; $display("FAIL clean_err got=%0d/%b want=0/0", bus0.err_count, bus0.first_err_valid); end
    endtask

    task automatic test_p2y_stuck0();
        int c;
        mode0 = 1;
        run_big(c);
        total++; if (bus0.err_count !== 11'd448) begin bad++; $display("FAIL p2y0_err got=%0d want=448", bus0.err_count); end
        total++; if (bus0.first_err_vec !== 10'd192) begin bad++; $display("FAIL p2y0_first got=%0d want=192", bus0.first_err_vec); end
        total++; if (bus0.pass !== 1'b0 || bus0.done !== 1'b1) begin bad++; $display("FAIL p2y0_pass got pass=%b done=%b want 0/1", bus0.pass, bus0.done); end
    endtask

    task automatic test_p1y_stuck1();
        int c;
        mode0 = 2;
        run_big(c);
        total++; if (bus0.err_count !== 11'd784) begin bad++; $display("FAIL p1y1_err got=%0d want=784", bus0.err_count); end
        total++; if (bus0.first_err_vec !== 10'd0 || bus0.first_err_valid !== 1'b1) begin bad++; $display("FAIL p1y1_first got=%0d/%b want=0/1", bus0.first_err_vec, bus0.first_err_valid); end
    endtask

    task automatic test_rst_mid_run();
        int c;
        mode0 = 2;
        pulse_start(0);
        repeat (100) @(posedge clk);
        #1;
        total++; if (bus0.busy !== 1'b1) begin bad++; $display("FAIL midrun_busy got=%b want=1", bus0.busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin bad++; $display("FAIL abort_flags got busy=%b done=%b want 0/0", bus0.busy, bus0.done); end
        total++; if (pins0 !== 10'd0) begin bad++; $display("FAIL abort_pins got=%h want=000", pins0); end
        total++; if (bus0.err_count !== 11'd0 || bus0.first_err_valid !== 1'b0) begin bad++; $display("FAIL abort_err got=%0d/%b want=0/0", bus0.err_count, bus0.first_err_valid); end
        rst = 1'b0;
        mode0 = 0;
        run_big(c);
        total++; if (c !== 3072 || bus0.pass !== 1'b1 || bus0.err_count !== 11'd0) begin bad++; $display("FAIL after_abort_run got cycles=%0d pass=%b err=%0d want 3072/1/0", c, bus0.pass, bus0.err_count); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        mode0 = 0;
        mode1 = 0;
        glitch_en = 1'b0;
        rst = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        test_reset();
        test_small_run();
        test_small_restart();
        test_clean_run();
        test_p2y_stuck0();
        test_p1y_stuck1();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
